// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared access-size encodings, FSM states and lane count for the memory stage
package mem_access_stage_pkg;
    localparam int NUM_LANES = 8;
    localparam logic [2:0] LS_B  = 3'd0;
    localparam logic [2:0] LS_H  = 3'd1;
    localparam logic [2:0] LS_W  = 3'd2;
    localparam logic [2:0] LS_D  = 3'd3;
    localparam logic [2:0] LS_BU = 3'd4;
    localparam logic [2:0] LS_HU = 3'd5;
    localparam logic [2:0] LS_WU = 3'd6;
    typedef enum logic {IDLE, WAIT_RSP} state_t;
endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// load_store_align: byte-lane placement of store data, alignment check and load extraction/extension
module load_store_align
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            i_off,
    input  logic [2:0]            i_func3,
    input  logic                  i_mem_op,
    input  logic                  i_store,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic [DATA_WIDTH-1:0] i_load_word,
    output logic [NUM_LANES-1:0]  o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_misaligned,
    output logic [DATA_WIDTH-1:0] o_load_data
);
    // func3[1:0] is the size (b/h/w/d) for both signed and unsigned forms; func3[2] selects zero-extension
    logic [1:0]            size;
    logic                  sgn;
    logic [DATA_WIDTH-1:0] sh;
    always_comb begin
        size         = i_func3[1:0];
        sgn          = ~i_func3[2];
        o_misaligned = i_mem_op & ((size == LS_H[1:0] & i_off[0]) |
                                   (size == LS_W[1:0] & |i_off[1:0]) |
                                   (size == LS_D[1:0] & |i_off));
        o_be         = ~i_store              ? 8'hFF :
                       size == LS_B[1:0]     ? 8'h01 << i_off :
                       size == LS_H[1:0]     ? 8'h03 << i_off :
                       size == LS_W[1:0]     ? 8'h0F << i_off : 8'hFF;
        o_wdata      = size == LS_B[1:0] ? {(DATA_WIDTH/8){i_store_data[7:0]}} :
                       size == LS_H[1:0] ? {(DATA_WIDTH/16){i_store_data[15:0]}} :
                       size == LS_W[1:0] ? {(DATA_WIDTH/32){i_store_data[31:0]}} : i_store_data;
        sh           = i_load_word >> {i_off, 3'b000};
        o_load_data  = size == LS_B[1:0] ? {{(DATA_WIDTH-8){sgn & sh[7]}}, sh[7:0]} :
                       size == LS_H[1:0] ? {{(DATA_WIDTH-16){sgn & sh[15]}}, sh[15:0]} :
                       size == LS_W[1:0] ? {{(DATA_WIDTH-32){sgn & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory handshake, stall generation and writeback pipeline register
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [2:0]            i_func3,
    input  logic                  i_mem_we,
    input  logic                  i_load_instr,
    input  logic                  i_reg_we,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]            i_result_src,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0] i_pc_target,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    output logic                  o_dmem_req_valid,
    input  logic                  i_dmem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic                  o_dmem_we,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    output logic [NUM_LANES-1:0]  o_dmem_be,
    input  logic                  i_dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_dmem_rsp_data,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target,
    output logic [2:0]            o_result_src,
    output logic                  o_reg_we,
    output logic [REG_ADDR_W-1:0] o_rd_addr
);
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d, alu_result_q, alu_result_d, imm_ext_q, imm_ext_d;
    logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d, pc_target_q, pc_target_d;
    logic [2:0]            result_src_q, result_src_d;
    logic                  reg_we_q, reg_we_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  mem_op, access, idle;
    logic [DATA_WIDTH-1:0] load_data;

    load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_off        (i_alu_result[2:0]),
        .i_func3      (i_func3),
        .i_mem_op     (mem_op),
        .i_store      (i_mem_we),
        .i_store_data (i_write_data),
        .i_load_word  (i_dmem_rsp_data),
        .o_be         (o_dmem_be),
        .o_wdata      (o_dmem_wdata),
        .o_misaligned (o_misaligned),
        .o_load_data  (load_data)
    );

    always_comb begin
        mem_op           = i_mem_we | i_load_instr;
        access           = mem_op & ~o_misaligned;
        idle             = state_q == IDLE;
        o_dmem_req_valid = idle & access;
        o_dmem_addr      = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
        o_dmem_we        = i_mem_we;
        o_stall          = idle ? access & ~(i_dmem_req_ready & i_mem_we) : ~i_dmem_rsp_valid;
        // a store wins if both flags are set; only an accepted load waits for a response
        state_d          = idle ? ((access & i_dmem_req_ready & ~i_mem_we) ? WAIT_RSP : IDLE)
                                : (i_dmem_rsp_valid ? IDLE : WAIT_RSP);
        reg_we_d         = i_reg_we & ~o_misaligned & ~o_stall;
        read_data_d      = (~idle & i_load_instr) ? load_data : '0;
        alu_result_d     = i_alu_result;
        imm_ext_d        = i_imm_ext;
        pc_plus4_d       = i_pc_plus4;
        pc_target_d      = i_pc_target;
        result_src_d     = i_result_src;
        rd_addr_d        = i_rd_addr;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q      <= IDLE;
            read_data_q  <= '0;
            alu_result_q <= '0;
            imm_ext_q    <= '0;
            pc_plus4_q   <= '0;
            pc_target_q  <= '0;
            result_src_q <= '0;
            reg_we_q     <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            imm_ext_q    <= imm_ext_d;
            pc_plus4_q   <= pc_plus4_d;
            pc_target_q  <= pc_target_d;
            result_src_q <= result_src_d;
            reg_we_q     <= reg_we_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign o_read_data  = read_data_q;
    assign o_alu_result = alu_result_q;
    assign o_imm_ext    = imm_ext_q;
    assign o_pc_plus4   = pc_plus4_q;
    assign o_pc_target  = pc_target_q;
    assign o_result_src = result_src_q;
    assign o_reg_we     = reg_we_q;
    assign o_rd_addr    = rd_addr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of handshake, stalls, lane placement, extension and reset
module tb_mem_access_stage;
    logic        i_clk = 1'b0, i_arst = 1'b1;
    logic [63:0] i_alu_result = '0, i_write_data = '0, i_imm_ext = '0, i_pc_plus4 = '0, i_pc_target = '0;
    logic [2:0]  i_func3 = '0, i_result_src = '0;
    logic        i_mem_we = 1'b0, i_load_instr = 1'b0, i_reg_we = 1'b0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_dmem_req_ready = 1'b0, i_dmem_rsp_valid = 1'b0;
    logic [63:0] i_dmem_rsp_data = '0;
    logic        o_dmem_req_valid, o_dmem_we, o_stall, o_misaligned, o_reg_we;
    logic [63:0] o_dmem_addr, o_dmem_wdata, o_read_data, o_alu_result, o_imm_ext, o_pc_plus4, o_pc_target;
    logic [7:0]  o_dmem_be;
    logic [2:0]  o_result_src;
    logic [4:0]  o_rd_addr;
    int n_tot = 0, n_pass = 0, n_fail = 0;

    mem_access_stage dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
        .i_func3(i_func3), .i_mem_we(i_mem_we), .i_load_instr(i_load_instr), .i_reg_we(i_reg_we),
        .i_rd_addr(i_rd_addr), .i_result_src(i_result_src), .i_pc_plus4(i_pc_plus4),
        .i_pc_target(i_pc_target), .i_imm_ext(i_imm_ext), .o_dmem_req_valid(o_dmem_req_valid),
        .i_dmem_req_ready(i_dmem_req_ready), .o_dmem_addr(o_dmem_addr), .o_dmem_we(o_dmem_we),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_rsp_valid(i_dmem_rsp_valid),
        .i_dmem_rsp_data(i_dmem_rsp_data), .o_stall(o_stall), .o_misaligned(o_misaligned),
        .o_read_data(o_read_data), .o_alu_result(o_alu_result), .o_imm_ext(o_imm_ext),
        .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target), .o_result_src(o_result_src),
        .o_reg_we(o_reg_we), .o_rd_addr(o_rd_addr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic op(input logic we, input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd, input logic rwe, input logic [4:0] rd);
        i_mem_we = we; i_load_instr = ld; i_func3 = f3; i_alu_result = addr;
        i_write_data = wd; i_reg_we = rwe; i_rd_addr = rd;
        #1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_reg_we", o_reg_we, 0);
        chk("rst_read_data", o_read_data, 0);
        chk("rst_alu_result", o_alu_result, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_req_valid", o_dmem_req_valid, 0);
        i_arst = 1'b0;
        tick();
        // lane placement while the memory is not ready (no edge in between)
        op(1, 0, 3'd0, 64'h1005, 64'hAB, 0, 0);
        chk("sb_be", o_dmem_be, 64'h20);
        chk("sb_wdata", o_dmem_wdata, 64'hABABABAB_ABABABAB);
        chk("sb_stall_not_ready", o_stall, 1);
        op(1, 0, 3'd1, 64'h1001, 64'h1234, 0, 0);
        chk("sh_misaligned", o_misaligned, 1);
        chk("sh_mis_no_req", o_dmem_req_valid, 0);
        op(1, 0, 3'd1, 64'h1002, 64'h1234, 0, 0);
        chk("sh_be", o_dmem_be, 64'h0C);
        chk("sh_wdata", o_dmem_wdata, 64'h12341234_12341234);
        tick();
        // sw accepted immediately
        i_dmem_req_ready = 1'b1;
        op(1, 0, 3'd2, 64'h1004, 64'hDEADBEEF, 0, 0);
        chk("sw_req_valid", o_dmem_req_valid, 1);
        chk("sw_be", o_dmem_be, 64'hF0);
        chk("sw_wdata", o_dmem_wdata, 64'hDEADBEEF_DEADBEEF);
        chk("sw_addr", o_dmem_addr, 64'h1000);
        chk("sw_we", o_dmem_we, 1);
        chk("sw_stall", o_stall, 0);
        tick();
        chk("sw_o_reg_we", o_reg_we, 0);
        chk("sw_o_alu_result", o_alu_result, 64'h1004);
        // lb, response one cycle after the wait cycle
        i_result_src = 3'd1;
        op(0, 1, 3'd0, 64'h2003, 0, 1, 5'd5);
        chk("lb_req_valid", o_dmem_req_valid, 1);
        chk("lb_be", o_dmem_be, 64'hFF);
        chk("lb_addr", o_dmem_addr, 64'h2000);
        chk("lb_stall_accept", o_stall, 1);
        tick();
        i_dmem_req_ready = 1'b0;
        #1;
        chk("lb_wait_no_req", o_dmem_req_valid, 0);
        chk("lb_wait_stall", o_stall, 1);
        chk("lb_bubble", o_reg_we, 0);
        tick();
        i_dmem_rsp_valid = 1'b1; i_dmem_rsp_data = 64'h11223344_80776655;
        #1;
        chk("lb_rsp_stall", o_stall, 0);
        tick();
        i_dmem_rsp_valid = 1'b0; i_dmem_req_ready = 1'b1;
        chk("lb_read_data", o_read_data, 64'hFFFFFFFF_FFFFFF80);
        chk("lb_reg_we", o_reg_we, 1);
        chk("lb_rd_addr", o_rd_addr, 5);
        chk("lb_result_src", o_result_src, 1);
        // lbu, minimal two-cycle latency
        op(0, 1, 3'd4, 64'h2003, 0, 1, 5'd6);
        tick();
        i_dmem_req_ready = 1'b0; i_dmem_rsp_valid = 1'b1;
        #1;
        chk("lbu_rsp_stall", o_stall, 0);
        tick();
        i_dmem_rsp_valid = 1'b0;
        chk("lbu_read_data", o_read_data, 64'h80);
        chk("lbu_rd_addr", o_rd_addr, 6);
        // lh with memory not ready for three cycles
        i_dmem_rsp_data = 64'hABCD0000_00000000;
        op(0, 1, 3'd1, 64'h2006, 0, 1, 5'd7);
        for (int k = 0; k < 3; k++) begin
            chk("lh_hold_valid", o_dmem_req_valid, 1);
            chk("lh_hold_addr", o_dmem_addr, 64'h2000);
            chk("lh_hold_stall", o_stall, 1);
            tick();
            chk("lh_hold_bubble", o_reg_we, 0);
        end
        i_dmem_req_ready = 1'b1;
        #1;
        chk("lh_accept_stall", o_stall, 1);
        tick();
        i_dmem_req_ready = 1'b0;
        #1;
        chk("lh_wait_no_req", o_dmem_req_valid, 0);
        i_dmem_rsp_valid = 1'b1;
        #1;
        chk("lh_rsp_stall", o_stall, 0);
        tick();
        i_dmem_rsp_valid = 1'b0;
        chk("lh_read_data", o_read_data, 64'hFFFFFFFF_FFFFABCD);
        chk("lh_reg_we", o_reg_we, 1);
        // misaligned lw
        i_dmem_req_ready = 1'b1;
        op(0, 1, 3'd2, 64'h3002, 0, 1, 5'd8);
        chk("lw_misaligned", o_misaligned, 1);
        chk("lw_no_req", o_dmem_req_valid, 0);
        chk("lw_stall", o_stall, 0);
        tick();
        chk("lw_reg_we", o_reg_we, 0);
        chk("lw_read_data", o_read_data, 0);
        // ld then back-to-back sd
        op(0, 1, 3'd3, 64'h4000, 0, 1, 5'd9);
        tick();
        i_dmem_req_ready = 1'b0; i_dmem_rsp_valid = 1'b1; i_dmem_rsp_data = 64'h01234567_89ABCDEF;
        #1;
        chk("ld_rsp_stall", o_stall, 0);
        tick();
        i_dmem_rsp_valid = 1'b0; i_dmem_req_ready = 1'b1;
        op(1, 0, 3'd3, 64'h4008, 64'h55AA55AA_12345678, 0, 0);
        chk("ld_read_data", o_read_data, 64'h01234567_89ABCDEF);
        chk("ld_reg_we", o_reg_we, 1);
        chk("sd_req_valid", o_dmem_req_valid, 1);
        chk("sd_be", o_dmem_be, 64'hFF);
        chk("sd_wdata", o_dmem_wdata, 64'h55AA55AA_12345678);
        chk("sd_stall", o_stall, 0);
        tick();
        chk("sd_reg_we", o_reg_we, 0);
        chk("sd_read_data", o_read_data, 0);
        // reset during WAIT_RSP, then a late response
        op(0, 1, 3'd3, 64'h5000, 0, 1, 5'd10);
        tick();
        i_dmem_req_ready = 1'b0;
        #1;
        chk("rst_mid_wait_stall", o_stall, 1);
        i_arst = 1'b1;
        op(0, 0, 3'd0, 64'h0, 0, 0, 0);
        chk("rst_mid_stall_idle", o_stall, 0);
        chk("rst_mid_reg_we", o_reg_we, 0);
        chk("rst_mid_alu_result", o_alu_result, 0);
        tick();
        i_arst = 1'b0;
        i_dmem_rsp_valid = 1'b1; i_dmem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("late_rsp_stall", o_stall, 0);
        chk("late_rsp_no_req", o_dmem_req_valid, 0);
        tick();
        i_dmem_rsp_valid = 1'b0;
        chk("late_rsp_read_data", o_read_data, 0);
        chk("late_rsp_reg_we", o_reg_we, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the execute pipeline-register outputs: ALU result used as address, store data, func3, mem_we, load flag, writeback controls.
- Runs a valid/ready handshake with the data memory, stalls the pipeline until the access completes, aligns and extends load data, and flags misaligned accesses.
- Ends in a pipeline register that feeds the writeback stage.

Parameters:
ADDR_WIDTH, 64, byte-address width
DATA_WIDTH, 64, data/register width; memory word = DATA_WIDTH bits, 8 byte lanes
REG_ADDR_W, 5, register-file address width

Ports:
i_clk  in  1  clock
i_arst  in  1  asynchronous active-high reset
i_alu_result  in  DATA_WIDTH  effective address / ALU result
i_write_data  in  DATA_WIDTH  store data (unaligned, low bytes valid)
i_func3  in  3  access size/sign: 0 b, 1 h, 2 w, 3 d, 4 bu, 5 hu, 6 wu
i_mem_we  in  1  store
i_load_instr  in  1  load
i_reg_we  in  1  writeback enable
i_rd_addr  in  REG_ADDR_W  destination register
i_result_src  in  3  writeback mux select
i_pc_plus4, i_pc_target  in  ADDR_WIDTH  passed to writeback
i_imm_ext  in  DATA_WIDTH  passed to writeback
o_dmem_req_valid  out  1  request valid
i_dmem_req_ready  in  1  memory accepts request
o_dmem_addr  out  ADDR_WIDTH  address with [2:0] forced to 0
o_dmem_we  out  1  write request
o_dmem_wdata  out  DATA_WIDTH  lane-shifted store data
o_dmem_be  out  8  byte enables
i_dmem_rsp_valid  in  1  read response valid
i_dmem_rsp_data  in  DATA_WIDTH  read word
o_stall  out  1  freeze upstream stages and hazard unit
o_misaligned  out  1  misaligned access, combinational, this cycle
o_read_data, o_alu_result, o_imm_ext  out  DATA_WIDTH  registered writeback data
o_pc_plus4, o_pc_target  out  ADDR_WIDTH  registered
o_result_src  out  3  registered
o_reg_we  out  1  registered
o_rd_addr  out  REG_ADDR_W  registered

Behaviour:
- Reset: FSM to IDLE; all registered outputs 0 (o_reg_we=0 gives a bubble).
- access = (i_mem_we | i_load_instr) & ~o_misaligned.
- Misaligned when:
  - h/hu with addr[0]≠0
  - w/wu with addr[1:0]≠0
  - d with addr[2:0]≠0
  - On misaligned: no request; captured o_reg_we forced to 0.
- FSM states: IDLE, WAIT_RSP.
  - IDLE: o_dmem_req_valid = access, combinational from held inputs.
    - Store accepted (valid & ready): completes this cycle, no stall.
    - Load accepted: go to WAIT_RSP.
    - Not accepted: o_stall=1, remain IDLE.
  - WAIT_RSP: req_valid=0; o_stall = ~i_dmem_rsp_valid. On rsp_valid: capture the extended data, return to IDLE.
  - Load latency = at least 2 cycles (accept cycle + response cycle).
  - rsp_valid seen in IDLE is ignored.
- o_stall = (IDLE & access & ~(i_dmem_req_ready & i_mem_we)) | (WAIT_RSP & ~i_dmem_rsp_valid).
- A request is never withdrawn while valid&~ready; inputs are held by the stall.
- Store lanes, off = addr[2:0]:
  - b: be = 1<<off, wdata = byte replicated ×8
  - h: be = 3<<off, half replicated ×4
  - w: be = 0x0F<<off, word replicated ×2
  - d: be = 0xFF, wdata = data
  - Loads: o_dmem_be = 0xFF.
- Load extraction: rsp_data >> (8*off), then truncate and extend per func3 (sign-extend for 0/1/2, zero-extend for 4/5/6, no change for 3).
- Pipeline register:
  - Loads when ~o_stall with all writeback fields.
  - While o_stall=1 it captures a bubble (o_reg_we=0, other fields don't-care), so writeback never double-writes.
  - o_read_data = 0 for non-loads.
- Reset mid-access: FSM returns to IDLE; an outstanding response arriving after reset is ignored.

Decomposition:
- Shared package holds:
  - func3 size encodings (LS_B…LS_WU)
  - FSM state enum {IDLE, WAIT_RSP}
  - byte-lane count constant 8
- One sub-module, load_store_align: purely combinational. Computes be, wdata, misaligned and load-extension.
- FSM and the pipeline register stay in the top.

Test Plan:
- sw, addr 0x1004, data 0x…DEADBEEF, ready=1 → req_valid=1, be=0xF0, wdata=0xDEADBEEF_DEADBEEF, stall=0, next o_reg_we=0.
- lb, addr 0x2003, ready=1, response 2 cycles later with byte3=0x80 → stall high 2 cycles, o_read_data=0xFFFF_FFFF_FFFF_FF80; lbu variant → 0x80.
- lh, ready low 3 cycles → req_valid held with addr/be stable, stall=1 for all 3 cycles plus the wait; bubbles captured (o_reg_we=0).
- lw, addr 0x3002 → o_misaligned=1, no req_valid, stall=0, o_reg_we=0.
- ld, addr 0x4000, rsp_data 0x0123456789ABCDEF → o_read_data identical; back-to-back sd next cycle accepted with be=0xFF.
- i_arst asserted in WAIT_RSP → state IDLE, outputs 0; a late rsp_valid is ignored, stall=0.
